// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned F3_BITS = 3;
   localparam int unsigned RD_BITS = 5;

   localparam logic [F3_BITS-1:0] F3_B  = 3'b000;
   localparam logic [F3_BITS-1:0] F3_H  = 3'b001;
   localparam logic [F3_BITS-1:0] F3_W  = 3'b010;
   localparam logic [F3_BITS-1:0] F3_BU = 3'b100;
   localparam logic [F3_BITS-1:0] F3_HU = 3'b101;

   localparam logic [3:0] CAUSE_ILLEGAL     = 4'd2;
   localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
   localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
   localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
   localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } lsu_state_t;

   // Request context kept from acceptance until the response is formed.
   typedef struct packed {
      logic               write;
      logic [F3_BITS-1:0] funct3;
      logic [XLEN-1:0]    addr;
      logic [RD_BITS-1:0] rd;
   } lsu_ctx_t;

endpackage

// File: rtl/lsu_load_align.sv
// Extracts and sign/zero-extends load data according to funct3.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] raw,
   output logic [31:0] data_c
);

   // Select the low byte/half/word and extend it.
   always_comb begin
      data_c = '0;
      case (funct3)
         F3_B:    data_c = {{24{raw[7]}}, raw[7:0]};
         F3_H:    data_c = {{16{raw[15]}}, raw[15:0]};
         F3_W:    data_c = raw;
         F3_BU:   data_c = {24'b0, raw[7:0]};
         F3_HU:   data_c = {16'b0, raw[15:0]};
         default: data_c = '0;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit: checks a request, drives data memory for one
// cycle, and returns extended load data or an exception one cycle later.
module lsu
   import lsu_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE = 32'h0100_0000,
   parameter logic [31:0] DMEM_SIZE = 32'h0010_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic [31:0] dmem_address,
   output logic        dmem_read_write,
   output logic [31:0] dmem_data_in,
   output logic [1:0]  dmem_access_size,
   input  logic [31:0] dmem_data_out,
   output logic        rsp_valid,
   output logic        rsp_we,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        exc_valid,
   output logic [3:0]  exc_cause,
   output logic [31:0] exc_addr
);

   localparam int unsigned AW1 = XLEN + 1;
   localparam logic [AW1-1:0] RANGE_LO = AW1'(DMEM_BASE);
   localparam logic [AW1-1:0] RANGE_HI = AW1'(DMEM_BASE) + AW1'(DMEM_SIZE) - AW1'(1);

   lsu_state_t      state, state_next;
   lsu_ctx_t        ctx_q;
   logic            fault_q;
   logic [3:0]      cause_q;
   logic            accept_c;
   logic            illegal_c, misalign_c, range_c, fault_c;
   logic [3:0]      cause_c;
   logic [AW1-1:0]  span_c, first_c, last_c;
   logic [31:0]     load_data_c;

   lsu_load_align u_align (
      .funct3 (ctx_q.funct3),
      .raw    (dmem_data_out),
      .data_c (load_data_c)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic and acceptance handshake.
   always_comb begin
      state_next = state;
      accept_c   = req_valid && req_ready;
      case (state)
         IDLE:    if (accept_c) state_next = ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    state_next = accept_c ? ACCESS : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Decode, alignment and range checks on the incoming request.
   always_comb begin
      illegal_c = 1'b1;
      span_c    = '0;
      case (req_funct3)
         F3_B:    begin illegal_c = 1'b0;      span_c = AW1'(0); end
         F3_H:    begin illegal_c = 1'b0;      span_c = AW1'(1); end
         F3_W:    begin illegal_c = 1'b0;      span_c = AW1'(3); end
         F3_BU:   begin illegal_c = req_write; span_c = AW1'(0); end
         F3_HU:   begin illegal_c = req_write; span_c = AW1'(1); end
         default: begin illegal_c = 1'b1;      span_c = AW1'(0); end
      endcase
      misalign_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
      first_c    = {1'b0, req_addr};
      last_c     = first_c + span_c;
      range_c    = (first_c < RANGE_LO) || (last_c > RANGE_HI);
      cause_c    = '0;
      if (illegal_c)       cause_c = CAUSE_ILLEGAL;
      else if (misalign_c) cause_c = req_write ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
      else if (range_c)    cause_c = req_write ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
      fault_c    = illegal_c || misalign_c || range_c;
   end

   // Request capture, one-cycle memory drive, and registered response.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_ready        <= 1'b1;
         ctx_q            <= '0;
         fault_q          <= 1'b0;
         cause_q          <= '0;
         dmem_address     <= '0;
         dmem_read_write  <= 1'b0;
         dmem_data_in     <= '0;
         dmem_access_size <= '0;
         rsp_valid        <= 1'b0;
         rsp_we           <= 1'b0;
         rsp_rd           <= '0;
         rsp_data         <= '0;
         exc_valid        <= 1'b0;
         exc_cause        <= '0;
         exc_addr         <= '0;
      end else begin
         req_ready        <= (state_next != ACCESS);
         dmem_address     <= '0;
         dmem_read_write  <= 1'b0;
         dmem_data_in     <= '0;
         dmem_access_size <= '0;
         rsp_valid        <= 1'b0;
         rsp_we           <= 1'b0;
         rsp_rd           <= '0;
         rsp_data         <= '0;
         exc_valid        <= 1'b0;
         exc_cause        <= '0;
         exc_addr         <= '0;
         if (accept_c) begin
            ctx_q   <= '{write: req_write, funct3: req_funct3, addr: req_addr, rd: req_rd};
            fault_q <= fault_c;
            cause_q <= cause_c;
            if (!fault_c) begin
               dmem_address     <= req_addr;
               dmem_read_write  <= req_write;
               dmem_data_in     <= req_write ? req_wdata : '0;
               dmem_access_size <= req_funct3[1:0];
            end
         end
         if (state == ACCESS) begin
            rsp_valid <= 1'b1;
            rsp_rd    <= ctx_q.rd;
            rsp_we    <= !ctx_q.write && !fault_q && (ctx_q.rd != '0);
            rsp_data  <= (!ctx_q.write && !fault_q) ? load_data_c : '0;
            exc_valid <= fault_q;
            exc_cause <= cause_q;
            exc_addr  <= fault_q ? ctx_q.addr : '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random requests against a transaction-level model.
module tb_lsu;

   localparam logic [31:0] BASE = 32'h0100_0000;
   localparam logic [31:0] SIZE = 32'h0010_0000;
   localparam int MEMW = 4096;
   localparam int MAXN = 64;

   typedef struct packed {
      logic        write;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
   } req_t;

   typedef struct packed {
      logic        ready_acc;
      logic        ready_access;
      logic        rspv_access;
      logic        rw;
      logic [31:0] addr;
      logic [1:0]  size;
      logic [31:0] din;
      logic        rw_resp;
      logic        rspv;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        excv;
      logic [3:0]  cause;
      logic [31:0] eaddr;
   } obs_t;

   logic        clock;
   logic        reset;
   logic        req_valid, req_ready, req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic [31:0] dmem_address, dmem_data_in, dmem_data_out;
   logic        dmem_read_write;
   logic [1:0]  dmem_access_size;
   logic        rsp_valid, rsp_we, exc_valid;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data, exc_addr;
   logic [3:0]  exc_cause;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem     [0:MEMW-1];
   logic [7:0] ref_mem [0:MEMW-1];
   req_t rq [0:MAXN-1];
   obs_t ex [0:MAXN-1];
   obs_t ob [0:MAXN-1];
   int   nreq;

   lsu #(.DMEM_BASE(BASE), .DMEM_SIZE(SIZE)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_address(dmem_address), .dmem_read_write(dmem_read_write),
      .dmem_data_in(dmem_data_in), .dmem_access_size(dmem_access_size),
      .dmem_data_out(dmem_data_out),
      .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rd(rsp_rd), .rsp_data(rsp_data),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Byte window of the data memory, aliased modulo MEMW.
   function automatic int unsigned idx(input logic [31:0] a, input int k);
      return (a - BASE + 32'(k)) & 32'(MEMW - 1);
   endfunction

   // Behavioural data memory: combinational read, write on the strobe edge.
   initial begin
      for (int i = 0; i < MEMW; i++) mem[i] = 8'(i * 13 + 7);
      forever begin
         @(posedge clock);
         if (dmem_read_write === 1'b1) begin
            for (int k = 0; k < (dmem_access_size == 2'd0 ? 1 : (dmem_access_size == 2'd1 ? 2 : 4)); k++)
               mem[idx(dmem_address, k)] = dmem_data_in[8*k +: 8];
         end
      end
   end

   always_comb begin
      dmem_data_out = '0;
      for (int k = 0; k < 4; k++) dmem_data_out[8*k +: 8] = mem[idx(dmem_address, k)];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Transaction-level expectation of one request; applies stores to ref_mem.
   function automatic obs_t model(input req_t r);
      obs_t e;
      int n;
      bit legal, mis, oor;
      longint lo;
      logic [31:0] v;
      e = '0;
      e.ready_acc = 1'b1;
      e.rspv = 1'b1;
      e.rd = r.rd;
      legal = r.write ? (r.f3 inside {3'd0, 3'd1, 3'd2}) : (r.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      case (r.f3)
         3'd0, 3'd4: n = 1;
         3'd1, 3'd5: n = 2;
         default:    n = 4;
      endcase
      mis = (int'(r.addr[1:0]) % n) != 0;
      lo  = longint'(r.addr);
      oor = (lo < longint'(BASE)) || (lo + n - 1 > longint'(BASE) + longint'(SIZE) - 1);
      if (!legal)   e.cause = 4'd2;
      else if (mis) e.cause = r.write ? 4'd6 : 4'd4;
      else if (oor) e.cause = r.write ? 4'd7 : 4'd5;
      if (e.cause != 4'd0) begin
         e.excv  = 1'b1;
         e.eaddr = r.addr;
      end else begin
         e.rw   = r.write;
         e.addr = r.addr;
         e.size = 2'(n == 1 ? 0 : (n == 2 ? 1 : 2));
         e.din  = r.write ? r.wdata : 32'd0;
         if (r.write) begin
            for (int k = 0; k < n; k++) ref_mem[idx(r.addr, k)] = r.wdata[8*k +: 8];
         end else begin
            v = '0;
            for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[idx(r.addr, k)];
            if ((r.f3 == 3'd0 || r.f3 == 3'd1) && v[8*n-1])
               for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
            e.data = v;
            e.we   = (r.rd != 5'd0);
         end
      end
      return e;
   endfunction

   function automatic req_t mk(input bit w, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d, input logic [4:0] rd);
      req_t r;
      r.write = w; r.f3 = f3; r.addr = a; r.wdata = d; r.rd = rd;
      return r;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int k, v;
      r.write = 1'($urandom_range(0, 1));
      v = $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0) r.f3 = 3'($urandom);
      else if (r.write)              r.f3 = 3'($urandom_range(0, 2));
      else                           r.f3 = 3'(v < 3 ? v : v + 1);
      k = $urandom_range(0, 9);
      if (k < 7) begin
         r.addr = BASE + 32'($urandom_range(0, MEMW - 1));
         if ($urandom_range(0, 1) == 1) r.addr[1:0] = 2'b00;
      end else if (k == 7) r.addr = BASE + SIZE - 32'($urandom_range(0, 8));
      else if (k == 8)     r.addr = BASE - 32'($urandom_range(1, 8));
      else                 r.addr = $urandom;
      r.wdata = $urandom;
      r.rd    = 5'($urandom_range(0, 31));
      return r;
   endfunction

   task automatic drive(input req_t r);
      req_write  = r.write;
      req_funct3 = r.f3;
      req_addr   = r.addr;
      req_wdata  = r.wdata;
      req_rd     = r.rd;
   endtask

   task automatic grab_resp(input int i);
      ob[i].rw_resp = dmem_read_write;
      ob[i].rspv    = rsp_valid;
      ob[i].we      = rsp_we;
      ob[i].rd      = rsp_rd;
      ob[i].data    = rsp_data;
      ob[i].excv    = exc_valid;
      ob[i].cause   = exc_cause;
      ob[i].eaddr   = exc_addr;
   endtask

   // Issues rq[0..nreq-1] (optionally holding req_valid high) and checks each against the model.
   task automatic run_batch(input string name, input bit b2b);
      for (int i = 0; i < nreq; i++) ex[i] = model(rq[i]);
      for (int i = 0; i < nreq; i++) begin
         ob[i] = '0;
         drive(rq[i]);
         req_valid = 1'b1;
         @(negedge clock);
         ob[i].ready_acc = req_ready;
         if (b2b && i > 0) grab_resp(i - 1);
         @(posedge clock); #1;
         if (b2b && i < nreq - 1) drive(rq[i + 1]);
         else req_valid = 1'b0;
         @(negedge clock);
         ob[i].ready_access = req_ready;
         ob[i].rspv_access  = rsp_valid;
         ob[i].rw           = dmem_read_write;
         ob[i].addr         = ex[i].excv ? 32'd0 : dmem_address;
         ob[i].size         = ex[i].excv ? 2'd0 : dmem_access_size;
         ob[i].din          = ex[i].excv ? 32'd0 : dmem_data_in;
         @(posedge clock); #1;
         if (!b2b || i == nreq - 1) begin
            @(negedge clock);
            grab_resp(i);
            @(posedge clock); #1;
         end
      end
      for (int i = 0; i < nreq; i++) begin
         checks++;
         if (ob[i] !== ex[i]) begin
            errors++;
            $display("FAIL %s[%0d] got %h want %h", name, i, ob[i], ex[i]);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      req_valid = 1'b0;
      drive(mk(1'b0, 3'd0, 32'd0, 32'd0, 5'd0));
      #12;
      checks++;
      if ({req_ready, rsp_valid, rsp_we, exc_valid} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_flags got %b want 1000", {req_ready, rsp_valid, rsp_we, exc_valid});
      end
      checks++;
      if ({rsp_rd, rsp_data, exc_cause, exc_addr} !== 73'd0) begin
         errors++;
         $display("FAIL reset_rsp got %h want 0", {rsp_rd, rsp_data, exc_cause, exc_addr});
      end
      checks++;
      if ({dmem_address, dmem_read_write, dmem_data_in, dmem_access_size} !== 67'd0) begin
         errors++;
         $display("FAIL reset_dmem got %h want 0", {dmem_address, dmem_read_write, dmem_data_in, dmem_access_size});
      end
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_store_load;
      nreq = 5;
      rq[0] = mk(1'b1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF, 5'd3);
      rq[1] = mk(1'b0, 3'b010, 32'h0100_0010, 32'd0, 5'd5);
      rq[2] = mk(1'b0, 3'b000, 32'h0100_0013, 32'd0, 5'd6);
      rq[3] = mk(1'b0, 3'b100, 32'h0100_0013, 32'd0, 5'd7);
      rq[4] = mk(1'b0, 3'b001, 32'h0100_0012, 32'd0, 5'd8);
      run_batch("store_load", 1'b0);
      checks++;
      if ({ob[0].rw, ob[0].size, ob[0].rw_resp} !== 4'b1100) begin
         errors++;
         $display("FAIL sw_strobe got %b want 1100", {ob[0].rw, ob[0].size, ob[0].rw_resp});
      end
      checks++;
      if (ob[1].data !== 32'hDEAD_BEEF || ob[1].we !== 1'b1) begin
         errors++;
         $display("FAIL lw_data got %h/%b want deadbeef/1", ob[1].data, ob[1].we);
      end
      checks++;
      if ({ob[2].data, ob[3].data, ob[4].data} !== {32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD}) begin
         errors++;
         $display("FAIL lb_lbu_lh got %h %h %h want ffffffde 000000de ffffdead", ob[2].data, ob[3].data, ob[4].data);
      end
   endtask

   task automatic test_faults;
      logic [3:0] cw [8];
      cw = '{4'd4, 4'd6, 4'd5, 4'd6, 4'd7, 4'd5, 4'd2, 4'd2};
      nreq = 8;
      rq[0] = mk(1'b0, 3'b010, 32'h0100_0002, 32'd0, 5'd4);
      rq[1] = mk(1'b1, 3'b001, 32'h0100_0001, 32'h1111_2222, 5'd0);
      rq[2] = mk(1'b0, 3'b010, 32'h00FF_FFFC, 32'd0, 5'd9);
      rq[3] = mk(1'b1, 3'b010, BASE + SIZE - 32'd2, 32'h3333_4444, 5'd0);
      rq[4] = mk(1'b1, 3'b010, BASE + SIZE, 32'h5555_6666, 5'd0);
      rq[5] = mk(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0, 5'd10);
      rq[6] = mk(1'b0, 3'b011, 32'h0100_0001, 32'd0, 5'd11);
      rq[7] = mk(1'b1, 3'b100, 32'h0100_0000, 32'h7777_8888, 5'd0);
      run_batch("faults", 1'b0);
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (ob[i].excv !== 1'b1 || ob[i].cause !== cw[i] || ob[i].rw !== 1'b0) begin
            errors++;
            $display("FAIL fault_cause[%0d] got exc=%b cause=%0d rw=%b want exc=1 cause=%0d rw=0",
                     i, ob[i].excv, ob[i].cause, ob[i].rw, cw[i]);
         end
      end
      checks++;
      if (ob[0].eaddr !== 32'h0100_0002 || ob[0].we !== 1'b0 || ob[0].data !== 32'd0) begin
         errors++;
         $display("FAIL lw_misalign_fields got %h/%b/%h want 01000002/0/0", ob[0].eaddr, ob[0].we, ob[0].data);
      end
   endtask

   task automatic test_back_to_back;
      nreq = 8;
      rq[0] = mk(1'b1, 3'b010, 32'h0100_0100, 32'hCAFE_F00D, 5'd1);
      rq[1] = mk(1'b0, 3'b010, 32'h0100_0100, 32'd0, 5'd0);
      rq[2] = mk(1'b0, 3'b001, 32'h0100_0102, 32'd0, 5'd12);
      rq[3] = mk(1'b1, 3'b000, 32'h0100_0101, 32'h0000_0080, 5'd0);
      rq[4] = mk(1'b0, 3'b100, 32'h0100_0101, 32'd0, 5'd13);
      for (int i = 5; i < 8; i++) rq[i] = rand_req();
      run_batch("back_to_back", 1'b1);
      checks++;
      if (ob[1].we !== 1'b0 || ob[1].data !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL rd0_load got we=%b data=%h want we=0 data=cafef00d", ob[1].we, ob[1].data);
      end
      checks++;
      if (ob[4].data !== 32'h0000_0080) begin
         errors++;
         $display("FAIL b2b_lbu got %h want 00000080", ob[4].data);
      end
   endtask

   task automatic test_random;
      for (int b = 0; b < 4; b++) begin
         nreq = 16;
         for (int i = 0; i < nreq; i++) rq[i] = rand_req();
         run_batch("random", 1'(b % 2));
      end
   endtask

   task automatic test_reset_mid_access;
      drive(mk(1'b1, 3'b010, 32'h0100_0040, 32'h1234_5678, 5'd0));
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      checks++;
      if (dmem_read_write !== 1'b1) begin
         errors++;
         $display("FAIL rst_access_strobe got %b want 1", dmem_read_write);
      end
      reset = 1'b0;
      #1;
      checks++;
      if (dmem_read_write !== 1'b0) begin
         errors++;
         $display("FAIL rst_strobe_drop got %b want 0", dmem_read_write);
      end
      repeat (2) begin
         @(negedge clock);
         checks++;
         if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_rsp got %b want 0", rsp_valid);
         end
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clock);
         checks++;
         if ({req_ready, rsp_valid, dmem_read_write} !== 3'b100) begin
            errors++;
            $display("FAIL rst_release got %b want 100", {req_ready, rsp_valid, dmem_read_write});
         end
      end
      @(posedge clock); #1;
      nreq = 1;
      rq[0] = mk(1'b0, 3'b010, 32'h0100_0040, 32'd0, 5'd9);
      run_batch("after_reset", 1'b0);
   endtask

   initial begin
      for (int i = 0; i < MEMW; i++) ref_mem[i] = 8'(i * 13 + 7);
      test_reset;
      test_store_load;
      test_faults;
      test_back_to_back;
      test_random;
      test_reset_mid_access;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
